// File: rtl/shift_op_scheduler.sv
// Two-requester round-robin scheduler for the ALU's serial logical shifter.
// One bit position is shifted per clock; the result is returned on a valid/ready port.
module shift_op_scheduler #(
  parameter int         DATA_W = 6,
  parameter int         AMT_W  = 3,
  parameter logic [1:0] OPC    = 2'b01,
  parameter int         CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_dir,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_dir,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [11:0]       rsp_out,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic               rr_ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               dir_q;
  logic               rsp_id_q;
  logic               rsp_valid_q;
  logic               busy_q;
  logic [CNT_W-1:0]   op_count_q;
  logic [11:0]        rsp_out_q;

  logic               gnt;
  logic [DATA_W-1:0]  sel_x;
  logic [AMT_W-1:0]   sel_amt;
  logic               sel_dir;
  logic               accept;
  logic [DATA_W-1:0]  shift_d;
  logic [AMT_W-1:0]   cnt_d;

  // ALU result word: opcode on top, unused middle bits forced to zero.
  function automatic logic [11:0] fmt_rsp(input logic [DATA_W-1:0] d);
    logic [11:0] r;
    r              = '0;
    r[11:10]       = OPC;
    r[DATA_W-1:0]  = d;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] d,
                                               input logic              right);
    return right ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  // With both valid the pointer decides; otherwise the lone valid requester wins.
  always_comb begin
    gnt       = (&req_valid) ? rr_ptr_q : req_valid[1];
    sel_x     = gnt ? req1_x   : req0_x;
    sel_amt   = gnt ? req1_amt : req0_amt;
    sel_dir   = gnt ? req1_dir : req0_dir;
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid[gnt]) begin
      req_ready[gnt] = 1'b1;
    end
    accept    = |(req_valid & req_ready);
    shift_d   = shift1(data_q, dir_q);
    cnt_d     = cnt_q - AMT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
      rsp_out_q   <= fmt_rsp('0);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= sel_x;
            cnt_q    <= sel_amt;
            dir_q    <= sel_dir;
            rsp_id_q <= gnt;
            busy_q   <= 1'b1;
            if (sel_amt == '0) begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
              rsp_out_q   <= fmt_rsp(sel_x);
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= shift_d;
          cnt_q  <= cnt_d;
          // Result is captured on the last shift so it is registered on entry to DONE.
          if (cnt_d == '0) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= fmt_rsp(shift_d);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= ~rsp_id_q;
            op_count_q  <= op_count_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_op_scheduler.sv
// Directed bench for shift_op_scheduler: latency, data, arbitration, stall and reset abort.
module tb_shift_op_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req0_x, req1_x;
  logic [2:0]  req0_amt, req1_amt;
  logic        req0_dir, req1_dir;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [11:0] rsp_out;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;
  int ops    = 0;

  always #5 clk = ~clk;

  shift_op_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_x(req1_x), .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic id, input logic [5:0] x, input logic [2:0] amt,
                      input logic d);
    if (id) begin
      req1_x = x; req1_amt = amt; req1_dir = d;
    end else begin
      req0_x = x; req0_amt = amt; req0_dir = d;
    end
  endtask

  // One request from a lone requester; optionally holds rsp_ready low for 'stall' cycles.
  task automatic run_op(input logic id, input logic [5:0] x, input logic [2:0] amt,
                        input logic d, input logic [5:0] exp_d, input int stall,
                        input string tag);
    int lat;
    load(id, x, amt, d);
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    chk({tag, "_ready"}, req_ready, id ? 2'b10 : 2'b01);
    tick();
    req_valid = 2'b00;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, int'(amt) + 1);
    chk({tag, "_rsp_out"}, rsp_out, {2'b01, 4'b0000, exp_d});
    chk({tag, "_rsp_id"}, rsp_id, id);
    if (stall > 0) req_valid = 2'b11;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_valid"}, rsp_valid, 1'b1);
      chk({tag, "_stall_out"}, rsp_out, {2'b01, 4'b0000, exp_d});
      chk({tag, "_stall_id"}, rsp_id, id);
      chk({tag, "_stall_ready"}, req_ready, 2'b00);
      chk({tag, "_stall_busy"}, busy, 1'b1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    ops++;
    chk({tag, "_op_count"}, op_count, ops);
    chk({tag, "_valid_low"}, rsp_valid, 1'b0);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    load(1'b0, 6'd0, 3'd0, 1'b0);
    load(1'b1, 6'd0, 3'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_count", op_count, 8'd0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_out", rsp_out, 12'b01_0000_000000);
    chk("rst_rsp_id", rsp_id, 1'b0);

    run_op(1'b0, 6'b101101, 3'd2, 1'b1, 6'b001011, 0, "t1_r2");
    run_op(1'b1, 6'b000111, 3'd3, 1'b0, 6'b111000, 0, "t2_l3");
    run_op(1'b0, 6'b010101, 3'd0, 1'b1, 6'b010101, 0, "t2_amt0");
    run_op(1'b1, 6'b111111, 3'd7, 1'b1, 6'b000000, 0, "t5_r7");
    run_op(1'b0, 6'b101010, 3'd6, 1'b0, 6'b000000, 0, "t5_l6");
    run_op(1'b1, 6'b110011, 3'd1, 1'b1, 6'b011001, 5, "t4_stall");

    // Both requesters held valid; last owner was requester 1, so grants go 0,1,0,1.
    load(1'b0, 6'b000001, 3'd1, 1'b0);
    load(1'b1, 6'b100000, 3'd1, 1'b1);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
        chk("t3_no_ready_busy", req_ready, 2'b00);
        tick();
        lat++;
      end
      chk("t3_latency", lat, 2);
      chk("t3_rsp_id", rsp_id, k % 2);
      chk("t3_rsp_out", rsp_out, (k % 2) ? 12'h410 : 12'h402);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      ops++;
      chk("t3_op_count", op_count, ops);
    end
    req_valid = 2'b00;
    tick();

    // Abort in SHIFT with two shifts left; request must not be replayed.
    load(1'b0, 6'b111000, 3'd4, 1'b1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("t6_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_valid_rst", rsp_valid, 1'b0);
    chk("t6_count_rst", op_count, 8'd0);
    chk("t6_out_rst", rsp_out, 12'b01_0000_000000);
    tick();
    reset = 1'b0;
    ops = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_replay", rsp_valid, 1'b0);
    end
    chk("t6_idle_busy", busy, 1'b0);
    run_op(1'b1, 6'b001100, 3'd2, 1'b0, 6'b110000, 0, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
